// File: rtl/period_meter.sv
// Period/high-time meter: times one period of an async square wave in clk cycles on request.
// Latency: sig_in synchroniser adds 2 cycles equally to every edge; done pulses on the cycle results update.
// Backpressure: none; start is a single-cycle request honoured only while idle, otherwise dropped.
module period_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state, state_nxt;

    logic s1, s2, prev;
    logic rise, fall;

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] hcnt, hcnt_nxt;
    logic [CNT_W-1:0] hlat, hlat_nxt;
    logic             hi_flag, hi_flag_nxt;

    logic [CNT_W-1:0] period_nxt, high_time_nxt;
    logic             overflow_nxt;
    logic             busy_nxt, done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= sig_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;
    assign fall = ~s2 & prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            hlat      <= '0;
            hi_flag   <= 1'b0;
            period    <= '0;
            high_time <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hcnt      <= hcnt_nxt;
            hlat      <= hlat_nxt;
            hi_flag   <= hi_flag_nxt;
            period    <= period_nxt;
            high_time <= high_time_nxt;
            overflow  <= overflow_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hcnt_nxt      = hcnt;
        hlat_nxt      = hlat;
        hi_flag_nxt   = hi_flag;
        period_nxt    = period;
        high_time_nxt = high_time;
        overflow_nxt  = overflow;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ARM;
                    cnt_nxt   = '0;
                end
            end

            ST_ARM: begin
                if (rise) begin
                    state_nxt   = ST_MEASURE;
                    cnt_nxt     = CNT_ONE;
                    hcnt_nxt    = CNT_ONE;
                    hlat_nxt    = '0;
                    hi_flag_nxt = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    state_nxt     = ST_DONE;
                    period_nxt    = '0;
                    high_time_nxt = '0;
                    overflow_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_MEASURE: begin
                // High time is latched internally; outputs only move on entry to DONE.
                if (fall && hi_flag) begin
                    hlat_nxt    = hcnt;
                    hi_flag_nxt = 1'b0;
                end else if (hi_flag) begin
                    hcnt_nxt = hcnt + 1'b1;
                end

                // A rise on the terminal count still closes a valid period.
                if (rise) begin
                    state_nxt     = ST_DONE;
                    period_nxt    = cnt;
                    high_time_nxt = hi_flag ? hcnt : hlat;
                    overflow_nxt  = 1'b0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt     = ST_DONE;
                    period_nxt    = CNT_MAX;
                    high_time_nxt = hi_flag ? CNT_MAX : hlat;
                    overflow_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status flags are registered copies of the next-state decode.
    assign busy_nxt = (state_nxt == ST_ARM) || (state_nxt == ST_MEASURE);
    assign done_nxt = (state_nxt == ST_DONE);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: 16-bit and 4-bit instances share clk, reset and sig_in.
module tb_period_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sig_in;
    logic        start_a, start_b;
    logic        busy_a, done_a, ovf_a;
    logic [15:0] period_a, high_a;
    logic        busy_b, done_b, ovf_b;
    logic [3:0]  period_b, high_b;

    int n_checks = 0;
    int n_fail   = 0;

    // waveform generator controls: mode 0 = low, 1 = high, 2 = periodic hi/lo
    int gen_mode;
    int gen_hi;
    int gen_lo;
    int phase;

    period_meter #(.CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(start_a),
        .busy(busy_a), .done(done_a), .period(period_a), .high_time(high_a), .overflow(ovf_a)
    );

    period_meter #(.CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(start_b),
        .busy(busy_b), .done(done_b), .period(period_b), .high_time(high_b), .overflow(ovf_b)
    );

    initial begin
        sig_in = 1'b0;
        phase  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_mode == 2) begin
                sig_in = (phase < gen_hi);
                phase  = (phase + 1 >= gen_hi + gen_lo) ? 0 : phase + 1;
            end else begin
                sig_in = (gen_mode == 1);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input bit use_b);
        @(posedge clk);
        #1;
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic set_wave(input int mode, input int hi, input int lo);
        @(negedge clk);
        gen_mode = mode;
        gen_hi   = hi;
        gen_lo   = lo;
        repeat (40) @(negedge clk);
    endtask

    function automatic logic [31:0] cur_period(input bit use_b);
        return use_b ? 32'(period_b) : 32'(period_a);
    endfunction

    function automatic logic [31:0] cur_high(input bit use_b);
        return use_b ? 32'(high_b) : 32'(high_a);
    endfunction

    // rise_at >= 0 switches sig_in to constant high on that wait iteration.
    task automatic run_meas(input bit use_b, input int rise_at, input int ep, input int eh,
                            input bit eo, input string tag);
        bit seen;
        bit busy_ok;
        seen    = 1'b0;
        busy_ok = 1'b1;
        pulse_start(use_b);
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (n == rise_at) gen_mode = 1;
            if (use_b ? done_b : done_a) seen = 1'b1;
            else if (!(use_b ? busy_b : busy_a)) busy_ok = 1'b0;
        end
        check({tag, "_busy_until_done"}, 32'(busy_ok), 32'd1);
        check({tag, "_done_seen"},       32'(seen),    32'd1);
        check({tag, "_busy_in_done"},    32'(use_b ? busy_b : busy_a), 32'd0);
        check({tag, "_period"},    cur_period(use_b), 32'(ep));
        check({tag, "_high_time"}, cur_high(use_b),   32'(eh));
        check({tag, "_overflow"},  32'(use_b ? ovf_b : ovf_a), 32'(eo));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(use_b ? done_b : done_a), 32'd0);
    endtask

    typedef struct {
        bit    use_b;
        int    mode;
        int    hi;
        int    lo;
        int    exp_period;
        int    exp_high;
        bit    exp_ovf;
        string tag;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int done_cnt;

        vecs[0] = '{1'b0, 2, 2, 2,  4, 2, 1'b0, "a_clk_div4"};
        vecs[1] = '{1'b0, 2, 1, 1,  2, 1, 1'b0, "a_clk_div2"};
        vecs[2] = '{1'b0, 2, 3, 7, 10, 3, 1'b0, "a_duty30"};
        vecs[3] = '{1'b0, 2, 5, 3,  8, 5, 1'b0, "a_h5_l3"};
        vecs[4] = '{1'b0, 2, 1, 4,  5, 1, 1'b0, "a_h1_l4"};
        vecs[5] = '{1'b1, 0, 0, 0,  0, 0, 1'b1, "b_arm_timeout"};
        vecs[6] = '{1'b1, 2, 5, 10, 15, 5, 1'b0, "b_period_max"};
        vecs[7] = '{1'b1, 2, 6, 10, 15, 6, 1'b1, "b_period_16"};
        vecs[8] = '{1'b1, 2, 2, 2,  4, 2, 1'b0, "b_clk_div4"};

        reset    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        gen_mode = 0;
        gen_hi   = 2;
        gen_lo   = 2;

        repeat (3) @(negedge clk);
        check("rst_busy",      32'(busy_a),   32'd0);
        check("rst_done",      32'(done_a),   32'd0);
        check("rst_period",    32'(period_a), 32'd0);
        check("rst_high_time", 32'(high_a),   32'd0);
        check("rst_overflow",  32'(ovf_a),    32'd0);
        check("rst_b_busy",    32'(busy_b),   32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            set_wave(vecs[i].mode, vecs[i].hi, vecs[i].lo);
            run_meas(vecs[i].use_b, -1, vecs[i].exp_period, vecs[i].exp_high,
                     vecs[i].exp_ovf, vecs[i].tag);
        end

        // single rise then held high: MEASURE times out with hi_flag still set
        set_wave(0, 2, 2);
        run_meas(1'b1, 3, 15, 15, 1'b1, "b_hold_high");

        // start re-pulsed while busy and during the DONE cycle
        set_wave(2, 3, 3);
        pulse_start(1'b0);
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_a) begin
                done_cnt++;
                start_a = 1'b1;
            end else if (busy_a) begin
                start_a = ~start_a;
            end else begin
                start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        check("restart_done_count", 32'(done_cnt), 32'd1);
        check("restart_period",     32'(period_a), 32'd6);
        check("restart_high_time",  32'(high_a),   32'd3);
        check("restart_idle",       32'(busy_a),   32'd0);

        // asynchronous reset in the middle of MEASURE
        set_wave(0, 2, 2);
        pulse_start(1'b0);
        repeat (3) @(negedge clk);
        gen_mode = 1;
        repeat (6) @(negedge clk);
        check("pre_reset_busy",   32'(busy_a),   32'd1);
        check("pre_reset_period", 32'(period_a), 32'd6);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy",      32'(busy_a),   32'd0);
        check("arst_done",      32'(done_a),   32'd0);
        check("arst_period",    32'(period_a), 32'd0);
        check("arst_high_time", 32'(high_a),   32'd0);
        check("arst_overflow",  32'(ovf_a),    32'd0);
        check("arst_b_period",  32'(period_b), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        set_wave(2, 2, 2);
        run_meas(1'b0, -1, 4, 2, 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
